// File: rtl/jtdsp16_boot_pkg.sv
// jtdsp16_boot_pkg
// Shared definitions for the jtdsp16 boot/run sequencer:
//   - ROM programming bus widths shared with the jtdsp16 core
//   - default end-of-program word
//   - sequencer state enumeration and registered status bundle
//   - checksum accumulation helper
package jtdsp16_boot_pkg;

    localparam int          PROG_AW      = 13;
    localparam int          PROG_DW      = 8;
    localparam logic [15:0] END_WORD_DEF = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_HOLD = 3'd3,
        ST_RUN  = 3'd4,
        ST_HALT = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Status outputs that are a pure function of the state being entered.
    typedef struct packed {
        logic dsp_rst;
        logic busy;
        logic halted;
        logic err;
    } status_t;

    // Status word to register alongside a transition into state st.
    function automatic status_t status_of(input state_t st);
        status_t s;
        s.dsp_rst = 1'b1;
        s.busy    = 1'b0;
        s.halted  = 1'b0;
        s.err     = 1'b0;
        case (st)
            ST_LOAD, ST_CHK, ST_HOLD: s.busy    = 1'b1;
            ST_RUN:                   s.dsp_rst = 1'b0;
            ST_HALT:                  s.halted  = 1'b1;
            ST_ERR:                   s.err     = 1'b1;
            default:                  s.dsp_rst = 1'b1;
        endcase
        return s;
    endfunction

    // Modulo-256 running checksum.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/jtdsp16_boot_if.sv
// jtdsp16_boot_if
// Host download channel plus DSP ROM programming port.
//   dl_data/dl_valid/dl_ready : byte stream from the host (valid/ready)
//   prog_addr/prog_data/prog_we : write port into the jtdsp16 program ROM
// Modports:
//   master : host / bench side (drives the byte stream, observes the ROM port)
//   slave  : boot sequencer side
interface jtdsp16_boot_if #(
    parameter int AW = jtdsp16_boot_pkg::PROG_AW
) ();
    import jtdsp16_boot_pkg::*;

    logic [7:0]         dl_data;
    logic               dl_valid;
    logic               dl_ready;
    logic [AW-1:0]      prog_addr;
    logic [PROG_DW-1:0] prog_data;
    logic               prog_we;

    modport master (
        output dl_data, dl_valid,
        input  dl_ready, prog_addr, prog_data, prog_we
    );

    modport slave (
        input  dl_data, dl_valid,
        output dl_ready, prog_addr, prog_data, prog_we
    );

endinterface

// File: rtl/jtdsp16_boot_edge.sv
// jtdsp16_boot_edge
// Registered, cen-qualified rising-edge detector for a DSP strobe
// (pods_n here, equally usable for pids_n).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : clock enable; detector state holds while low
//   sig        : strobe input
//   rise       : registered, high for one cen cycle after sig rises
module jtdsp16_boot_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic sig,
    output logic rise
);

    logic prev_r;
    logic rise_r;

    // Sample the strobe on enabled cycles; previous value resets to the idle-high level so reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
            rise_r <= 1'b0;
        end else if (cen) begin
            prev_r <= sig;
            rise_r <= sig & ~prev_r;
        end else begin
            prev_r <= prev_r;
            rise_r <= rise_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/jtdsp16_boot.sv
// jtdsp16_boot
// Boot and run sequencer for the jtdsp16 core. Holds the DSP in reset while
// a program image is streamed from the host into the ROM programming port,
// releases it after RST_HOLD cen cycles, and re-asserts reset when the DSP
// writes END_WORD on its parallel output port.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cen             : clock enable, all state advances only when high
//   start           : one-cycle request to (re)load and run
//   dl (slave)      : host byte stream and ROM programming port
//   dsp_rst         : registered active-high reset to jtdsp16
//   pbus_out,pods_n : DSP parallel output bus and strobe
//   busy            : LOAD, CHK or HOLD
//   done            : one-cycle pulse on end-word detection
//   halted, err     : level, HALT / ERR state
// Build option:
//   JTDSP16_BOOT_CHK_EN : adds a checksum trailer byte after the image
//   (CHK state); without it LEN bytes go straight to HOLD and err is 0.
module jtdsp16_boot
    import jtdsp16_boot_pkg::*;
#(
    parameter int          AW       = PROG_AW,
    parameter int          LEN      = 8192,
    parameter int          RST_HOLD = 16,
    parameter logic [15:0] END_WORD = END_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 start,
    jtdsp16_boot_if.slave        dl,
    output logic                 dsp_rst,
    input  logic [15:0]          pbus_out,
    input  logic                 pods_n,
    output logic                 busy,
    output logic                 done,
    output logic                 halted,
    output logic                 err
);

`ifdef JTDSP16_BOOT_CHK_EN
    localparam state_t LOAD_NEXT = ST_CHK;
    localparam logic   CHK_EN    = 1'b1;
`else
    localparam state_t LOAD_NEXT = ST_HOLD;
    localparam logic   CHK_EN    = 1'b0;
`endif

    localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);
    localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    state_t        state_r;
    status_t       stat_r;
    logic [AW-1:0] cnt_r;
    logic [7:0]    sum_r;
    logic [HW-1:0] hold_r;
    logic [AW-1:0] prog_addr_r;
    logic [7:0]    prog_data_r;
    logic          prog_we_r;
    logic          done_r;

    logic          xfer_s;
    logic          pods_rise_s;
    logic          end_s;

    jtdsp16_boot_edge u_pods_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .sig   (pods_n),
        .rise  (pods_rise_s)
    );

    assign dl.dl_ready = cen & ((state_r == ST_LOAD) | (state_r == ST_CHK));
    assign xfer_s      = dl.dl_valid & dl.dl_ready;
    assign end_s       = pods_rise_s & (pbus_out == END_WORD);

    // Sequencer: state, byte counter, checksum, hold counter and registered outputs.
    // prog_we/done are per-clk pulses, cleared on every clk so a stalled cen never stretches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            stat_r      <= status_of(ST_IDLE);
            cnt_r       <= '0;
            sum_r       <= 8'h00;
            hold_r      <= '0;
            prog_addr_r <= '0;
            prog_data_r <= 8'h00;
            prog_we_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            prog_we_r <= 1'b0;
            done_r    <= 1'b0;
            if (cen) begin
                case (state_r)
                    ST_IDLE, ST_HALT, ST_ERR: begin
                        if (start) begin
                            state_r <= ST_LOAD;
                            stat_r  <= status_of(ST_LOAD);
                            cnt_r   <= '0;
                            sum_r   <= 8'h00;
                        end
                    end
                    ST_LOAD: begin
                        if (xfer_s) begin
                            prog_addr_r <= cnt_r;
                            prog_data_r <= dl.dl_data;
                            prog_we_r   <= 1'b1;
                            cnt_r       <= cnt_r + 1'b1;
                            sum_r       <= sum8(sum_r, dl.dl_data);
                            if (cnt_r == LAST_ADDR) begin
                                state_r <= LOAD_NEXT;
                                stat_r  <= status_of(LOAD_NEXT);
                                hold_r  <= '0;
                            end
                        end
                    end
`ifdef JTDSP16_BOOT_CHK_EN
                    ST_CHK: begin
                        // Trailer byte closes the checksum; it is never written to the ROM.
                        if (xfer_s) begin
                            if (sum8(sum_r, dl.dl_data) == 8'h00) begin
                                state_r <= ST_HOLD;
                                stat_r  <= status_of(ST_HOLD);
                                hold_r  <= '0;
                            end else begin
                                state_r <= ST_ERR;
                                stat_r  <= status_of(ST_ERR);
                            end
                        end
                    end
`endif
                    ST_HOLD: begin
                        if (hold_r == HOLD_LAST) begin
                            state_r <= ST_RUN;
                            stat_r  <= status_of(ST_RUN);
                        end else begin
                            hold_r <= hold_r + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // A restart request takes priority over a coincident end word.
                        if (start) begin
                            state_r <= ST_LOAD;
                            stat_r  <= status_of(ST_LOAD);
                            cnt_r   <= '0;
                            sum_r   <= 8'h00;
                        end else if (end_s) begin
                            state_r <= ST_HALT;
                            stat_r  <= status_of(ST_HALT);
                            done_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        stat_r  <= status_of(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign dl.prog_addr = prog_addr_r;
    assign dl.prog_data = prog_data_r;
    assign dl.prog_we   = prog_we_r;
    assign dsp_rst      = stat_r.dsp_rst;
    assign busy         = stat_r.busy;
    assign halted       = stat_r.halted;
    assign err          = stat_r.err & CHK_EN;
    assign done         = done_r;

endmodule

// File: tb/tb_jtdsp16_boot.sv
// Self-checking bench for jtdsp16_boot (LEN=4, RST_HOLD=16).
module tb_jtdsp16_boot;

    localparam int AW       = 13;
    localparam int LEN      = 4;
    localparam int RST_HOLD = 16;
`ifdef JTDSP16_BOOT_CHK_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif
    localparam int N_TX = LEN + CHK_EXTRA;

    logic        clk = 1'b0;
    logic        rst_n, cen, start, pods_n;
    logic [15:0] pbus_out;
    logic        dsp_rst, busy, done, halted, err;

    jtdsp16_boot_if #(.AW(AW)) bus ();

    jtdsp16_boot #(.AW(AW), .LEN(LEN), .RST_HOLD(RST_HOLD), .END_WORD(16'hDEAD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .start    (start),
        .dl       (bus.slave),
        .dsp_rst  (dsp_rst),
        .pbus_out (pbus_out),
        .pods_n   (pods_n),
        .busy     (busy),
        .done     (done),
        .halted   (halted),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, failed = 0;
    int cyc = 0, done_cnt = 0, we_cen_low = 0;
    logic       cen_edge;
    logic [7:0] tx_q[$];
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    logic [7:0] fixed_img [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        cen_edge <= cen;
        #1;
        if (bus.prog_we === 1'b1) begin
            wr_addr_q.push_back(int'(bus.prog_addr));
            wr_data_q.push_back(bus.prog_data);
            wr_cyc_q.push_back(cyc);
            if (cen_edge !== 1'b1) we_cen_low <= we_cen_low + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_wr();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    endtask

    // Image model: LEN bytes plus, when the checksum is built in, the byte making the sum 0 mod 256.
    task automatic build_image(input bit fixed);
        logic [7:0] s;
        logic [7:0] b;
        tx_q.delete();
        s = 8'h00;
        for (int k = 0; k < LEN; k++) begin
            b = fixed ? fixed_img[k] : 8'($urandom);
            tx_q.push_back(b);
            s = s + b;
        end
        if (CHK_EXTRA == 1) tx_q.push_back(8'h00 - s);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offer tx_q[0..n-1]; rnd toggles cen every other cycle and randomizes dl_valid.
    task automatic send_bytes(input int n, input bit rnd);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 400) begin
            @(negedge clk);
            cen          = rnd ? budget[0] : 1'b1;
            bus.dl_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dl_data  = bus.dl_valid ? tx_q[idx] : 8'($urandom);
            #1;
            if (bus.dl_valid && bus.dl_ready) idx++;
            budget++;
        end
        @(negedge clk);
        bus.dl_valid = 1'b0;
        cen          = 1'b1;
        check("tx_timeout", 32'(budget < 400), 32'd1);
    endtask

    task automatic wait_run(output int fall_cyc);
        int b = 0;
        while (dsp_rst !== 1'b0 && b < 200) begin
            @(posedge clk); #1; b++;
        end
        fall_cyc = cyc;
        check("run_timeout", 32'(b < 200), 32'd1);
    endtask

    task automatic check_image(input string tag);
        check({tag, "_wr_count"}, wr_addr_q.size(), LEN);
        for (int k = 0; k < LEN && k < wr_addr_q.size(); k++) begin
            check({tag, "_addr"}, wr_addr_q[k], k);
            check({tag, "_data"}, wr_data_q[k], tx_q[k]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dsp_rst"},   dsp_rst,       32'd1);
        check({tag, "_prog_we"},   bus.prog_we,   32'd0);
        check({tag, "_prog_addr"}, bus.prog_addr, 32'd0);
        check({tag, "_prog_data"}, bus.prog_data, 32'd0);
        check({tag, "_busy"},      busy,          32'd0);
        check({tag, "_done"},      done,          32'd0);
        check({tag, "_halted"},    halted,        32'd0);
        check({tag, "_err"},       err,           32'd0);
        check({tag, "_dl_ready"},  bus.dl_ready,  32'd0);
    endtask

    initial begin
        int fall, d0;
        rst_n = 1'b0; cen = 1'b1; start = 1'b0; pods_n = 1'b1; pbus_out = 16'h0000;
        bus.dl_valid = 1'b0; bus.dl_data = 8'h00;
        #12;
        check_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;

        // Fixed image, valid always high: contiguous writes, then RST_HOLD of reset.
        build_image(1'b1);
        clear_wr();
        pulse_start();
        check("load_busy", busy, 32'd1);
        send_bytes(N_TX, 1'b0);
        wait_run(fall);
        check_image("fixed");
        for (int k = 1; k < wr_cyc_q.size(); k++)
            check("we_contiguous", wr_cyc_q[k] - wr_cyc_q[k-1], 32'd1);
        if (wr_cyc_q.size() > 0)
            check("hold_cycles", fall - wr_cyc_q[wr_cyc_q.size()-1], RST_HOLD + CHK_EXTRA);
        check("run_busy", busy, 32'd0);
        check("run_halted", halted, 32'd0);

        // Non-end word on the output port: nothing changes.
        d0 = done_cnt;
        @(negedge clk); pbus_out = 16'hCAFE; pods_n = 1'b0;
        @(negedge clk); pods_n = 1'b1;
        repeat (4) @(negedge clk);
        check("cafe_done", done_cnt - d0, 32'd0);
        check("cafe_dsp_rst", dsp_rst, 32'd0);
        check("cafe_halted", halted, 32'd0);

        // End word: done two clocks after the strobe rise, exactly once.
        d0 = done_cnt;
        @(negedge clk); pbus_out = 16'hDEAD; pods_n = 1'b0;
        @(negedge clk); pods_n = 1'b1;
        @(posedge clk); #2; check("dead_done_e0", done, 32'd0);
        @(posedge clk); #2; check("dead_done_e1", done, 32'd1);
        @(posedge clk); #2; check("dead_done_e2", done, 32'd0);
        repeat (2) @(negedge clk);
        check("dead_done_cnt", done_cnt - d0, 32'd1);
        check("dead_halted", halted, 32'd1);
        check("dead_dsp_rst", dsp_rst, 32'd1);
        check("dead_busy", busy, 32'd0);

        // Restart from HALT with random image, random valid and cen low every other cycle.
        build_image(1'b0);
        clear_wr();
        we_cen_low = 0;
        pulse_start();
        send_bytes(N_TX, 1'b1);
        wait_run(fall);
        check_image("rand_cen");
        check("we_while_cen_low", we_cen_low, 32'd0);

        // start coincident with the end-word edge: restart wins, no done.
        d0 = done_cnt;
        @(negedge clk); pbus_out = 16'hDEAD; pods_n = 1'b0;
        @(negedge clk); pods_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        check("abort_busy", busy, 32'd1);
        check("abort_dsp_rst", dsp_rst, 32'd1);
        check("abort_halted", halted, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);
        build_image(1'b0);
        clear_wr();
        send_bytes(N_TX, 1'b0);
        wait_run(fall);
        check_image("abort_reload");

        // Async reset after 2 of LEN bytes, then a full reload from address 0.
        build_image(1'b0);
        clear_wr();
        pulse_start();
        send_bytes(2, 1'b0);
        check("partial_wr_count", wr_addr_q.size(), 32'd2);
        #2; rst_n = 1'b0;
        #1;
        check_reset_vals("midload_rst");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle_ready", bus.dl_ready, 32'd0);
        build_image(1'b0);
        clear_wr();
        pulse_start();
        send_bytes(N_TX, 1'b0);
        wait_run(fall);
        check_image("after_rst");

`ifdef JTDSP16_BOOT_CHK_EN
        // Corrupted trailer: ERR, DSP kept in reset, trailer never written.
        build_image(1'b0);
        tx_q[LEN] = tx_q[LEN] + 8'h01;
        clear_wr();
        pulse_start();
        send_bytes(N_TX, 1'b0);
        repeat (3) @(negedge clk);
        check("bad_trailer_err", err, 32'd1);
        check("bad_trailer_dsp_rst", dsp_rst, 32'd1);
        check("bad_trailer_busy", busy, 32'd0);
        check("bad_trailer_wr_count", wr_addr_q.size(), LEN);
        build_image(1'b0);
        clear_wr();
        pulse_start();
        send_bytes(N_TX, 1'b0);
        wait_run(fall);
        check_image("after_err");
        check("after_err_err", err, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
